axi_burst_ram: RTL and testbench

- Parametrised AXI4 slave memory: the next generation of the main-memory block. It merges the AXI wrapper and RAM into one block.
- Adds configurable depth, byte-strobe writes, FIXED/INCR/WRAP bursts, SLVERR reporting and full-throughput reads under back-pressure.
- Sits behind the interconnect as the shared backing store for the coherent caches.

---
 rtl/axi_burst_ram.sv | 210 +++++++++++++++++++++
 tb/tb_axi_burst_ram.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_ram.sv
// axi_burst_ram: AXI4 slave RAM with byte-strobe writes, FIXED/INCR/WRAP bursts and a skid-buffered read path
module axi_burst_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 1,
  parameter int DEPTH      = 16384,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter     INIT_PATH  = ""
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [ID_WIDTH-1:0]   m_AWID,
  input  logic [ADDR_WIDTH-1:0] m_AWADDR,
  input  logic [7:0]            m_AWLEN,
  input  logic [2:0]            m_AWSIZE,
  input  logic [1:0]            m_AWBURST,
  input  logic                  m_AWVALID,
  output logic                  m_AWREADY,
  input  logic [DATA_WIDTH-1:0] m_WDATA,
  input  logic [STRB_WIDTH-1:0] m_WSTRB,
  input  logic                  m_WLAST,
  input  logic                  m_WVALID,
  output logic                  m_WREADY,
  output logic [ID_WIDTH-1:0]   m_BID,
  output logic [1:0]            m_BRESP,
  output logic                  m_BVALID,
  input  logic                  m_BREADY,
  input  logic [ID_WIDTH-1:0]   m_ARID,
  input  logic [ADDR_WIDTH-1:0] m_ARADDR,
  input  logic [7:0]            m_ARLEN,
  input  logic [2:0]            m_ARSIZE,
  input  logic [1:0]            m_ARBURST,
  input  logic                  m_ARVALID,
  output logic                  m_ARREADY,
  output logic [ID_WIDTH-1:0]   m_RID,
  output logic [DATA_WIDTH-1:0] m_RDATA,
  output logic [1:0]            m_RRESP,
  output logic                  m_RLAST,
  output logic                  m_RVALID,
  input  logic                  m_RREADY
);
  localparam int SW = $clog2(STRB_WIDTH);
  localparam int DI = $clog2(DEPTH);
  localparam logic [2:0] SWZ = 3'(SW);
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_BURST} r_state_t;
  function automatic logic [ADDR_WIDTH-1:0] f_next(input logic [ADDR_WIDTH-1:0] a, input logic [2:0] sz,
                                                   input logic [7:0] len, input logic [1:0] bt);
    logic [ADDR_WIDTH-1:0] inc, msk;
    inc = ADDR_WIDTH'(1) << sz;
    msk = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << sz) - ADDR_WIDTH'(1);
    return bt == 2'd0 ? a : bt == 2'd2 ? (a & ~msk) | ((a + inc) & msk) : a + inc;
  endfunction
  function automatic logic f_wrap_ok(input logic [7:0] len);
    return len inside {8'd1, 8'd3, 8'd7, 8'd15};
  endfunction
  // Illegal WRAP lengths and the reserved burst type fall back to INCR
  function automatic logic [1:0] f_burst(input logic [1:0] bt, input logic [7:0] len);
    return bt == 2'd0 ? 2'd0 : (bt == 2'd2 && f_wrap_ok(len)) ? 2'd2 : 2'd1;
  endfunction
  function automatic logic f_perr(input logic [1:0] bt, input logic [7:0] len, input logic [2:0] sz);
    return bt == 2'd3 || (bt == 2'd2 && !f_wrap_ok(len)) || sz > SWZ;
  endfunction
  function automatic logic f_oor(input logic [ADDR_WIDTH-1:0] a);
    return (a >> (SW + DI)) != '0;
  endfunction
  function automatic logic [DI-1:0] f_idx(input logic [ADDR_WIDTH-1:0] a);
    return a[SW +: DI];
  endfunction
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  w_state_t              r_wstate, w_wstate_nxt;
  logic [ID_WIDTH-1:0]   r_awid;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [7:0]            r_wlen, r_wcnt;
  logic [2:0]            r_wsize;
  logic [1:0]            r_wburst;
  logic                  r_werr;
  logic                  w_aw_hs, w_w_hs, w_wlast_cnt, w_w_oor;
  assign w_aw_hs     = m_AWVALID & m_AWREADY;
  assign w_w_hs      = m_WVALID & m_WREADY;
  assign w_wlast_cnt = r_wcnt == r_wlen;
  assign w_w_oor     = f_oor(r_waddr);
  always_ff @(posedge ACLK)
    if (ARESET) r_wstate <= W_IDLE;
    else r_wstate <= w_wstate_nxt;
  always_comb
    w_wstate_nxt = r_wstate == W_IDLE ? (w_aw_hs ? W_DATA : W_IDLE) :
                   r_wstate == W_DATA ? (w_w_hs && w_wlast_cnt ? W_RESP : W_DATA) :
                   r_wstate == W_RESP ? (m_BREADY ? W_IDLE : W_RESP) : W_IDLE;
  always_comb begin
    m_AWREADY = !ARESET && r_wstate == W_IDLE;
    m_WREADY  = !ARESET && r_wstate == W_DATA;
    m_BVALID  = !ARESET && r_wstate == W_RESP;
    m_BID     = m_BVALID ? r_awid : '0;
    m_BRESP   = m_BVALID && r_werr ? 2'd2 : 2'd0;
  end
  // A WLAST that disagrees with the beat counter flags the burst but never shortens it
  always_ff @(posedge ACLK)
    if (ARESET) begin
      r_awid   <= '0;
      r_waddr  <= '0;
      r_wlen   <= '0;
      r_wcnt   <= '0;
      r_wsize  <= '0;
      r_wburst <= '0;
      r_werr   <= 1'b0;
    end else if (w_aw_hs) begin
      r_awid   <= m_AWID;
      r_waddr  <= m_AWADDR;
      r_wlen   <= m_AWLEN;
      r_wcnt   <= '0;
      r_wsize  <= m_AWSIZE;
      r_wburst <= f_burst(m_AWBURST, m_AWLEN);
      r_werr   <= f_perr(m_AWBURST, m_AWLEN, m_AWSIZE);
    end else if (w_w_hs) begin
      r_waddr <= f_next(r_waddr, r_wsize, r_wlen, r_wburst);
      r_wcnt  <= r_wcnt + 8'd1;
      r_werr  <= r_werr | w_w_oor | (m_WLAST != w_wlast_cnt);
    end
  r_state_t              r_rstate, w_rstate_nxt;
  logic [ID_WIDTH-1:0]   r_arid;
  logic [ADDR_WIDTH-1:0] r_raddr;
  logic [7:0]            r_rlen, r_rcnt;
  logic [2:0]            r_rsize;
  logic [1:0]            r_rburst;
  logic                  r_rperr;
  logic                  r_s_v, r_s_last, r_s_err, r_s_oor;
  logic [ID_WIDTH-1:0]   r_s_id;
  logic [DATA_WIDTH-1:0] r_rq;
  logic                  r_k_v, r_k_last, r_k_err;
  logic [ID_WIDTH-1:0]   r_k_id;
  logic [DATA_WIDTH-1:0] r_k_data;
  logic                  w_ar_hs, w_rvalid, w_pop, w_s_left, w_issue;
  // The RAM output register is the younger buffer slot, the skid register the older one
  assign w_ar_hs  = m_ARVALID & m_ARREADY;
  assign w_rvalid = !ARESET && (r_k_v || r_s_v);
  assign w_pop    = w_rvalid & m_RREADY;
  assign w_s_left = r_s_v & !(w_pop & !r_k_v);
  assign w_issue  = !ARESET && r_rstate == R_BURST && (!(r_k_v && r_s_v) || w_pop);
  always_ff @(posedge ACLK)
    if (ARESET) r_rstate <= R_IDLE;
    else r_rstate <= w_rstate_nxt;
  always_comb
    w_rstate_nxt = r_rstate == R_IDLE ? (w_ar_hs ? R_BURST : R_IDLE) :
                   (w_issue && r_rcnt == r_rlen ? R_IDLE : R_BURST);
  always_comb begin
    m_ARREADY = !ARESET && r_rstate == R_IDLE;
    m_RVALID  = w_rvalid;
    m_RID     = !w_rvalid ? '0 : r_k_v ? r_k_id : r_s_id;
    m_RDATA   = !w_rvalid ? '0 : r_k_v ? r_k_data : r_s_oor ? '0 : r_rq;
    m_RLAST   = w_rvalid && (r_k_v ? r_k_last : r_s_last);
    m_RRESP   = w_rvalid && (r_k_v ? r_k_err : r_s_err) ? 2'd2 : 2'd0;
  end
  always_ff @(posedge ACLK)
    if (ARESET) begin
      r_arid   <= '0;
      r_raddr  <= '0;
      r_rlen   <= '0;
      r_rcnt   <= '0;
      r_rsize  <= '0;
      r_rburst <= '0;
      r_rperr  <= 1'b0;
    end else if (w_ar_hs) begin
      r_arid   <= m_ARID;
      r_raddr  <= m_ARADDR;
      r_rlen   <= m_ARLEN;
      r_rcnt   <= '0;
      r_rsize  <= m_ARSIZE;
      r_rburst <= f_burst(m_ARBURST, m_ARLEN);
      r_rperr  <= f_perr(m_ARBURST, m_ARLEN, m_ARSIZE);
    end else if (w_issue) begin
      r_raddr <= f_next(r_raddr, r_rsize, r_rlen, r_rburst);
      r_rcnt  <= r_rcnt + 8'd1;
    end
  always_ff @(posedge ACLK)
    if (ARESET) begin
      r_s_v    <= 1'b0;
      r_s_last <= 1'b0;
      r_s_err  <= 1'b0;
      r_s_oor  <= 1'b0;
      r_s_id   <= '0;
      r_k_v    <= 1'b0;
      r_k_last <= 1'b0;
      r_k_err  <= 1'b0;
      r_k_id   <= '0;
      r_k_data <= '0;
    end else begin
      if (!(r_k_v && !w_pop)) begin
        r_k_v    <= w_issue & w_s_left;
        r_k_last <= r_s_last;
        r_k_err  <= r_s_err;
        r_k_id   <= r_s_id;
        r_k_data <= r_s_oor ? '0 : r_rq;
      end
      if (w_issue) begin
        r_s_v    <= 1'b1;
        r_s_last <= r_rcnt == r_rlen;
        r_s_err  <= r_rperr | f_oor(r_raddr);
        r_s_oor  <= f_oor(r_raddr);
        r_s_id   <= r_arid;
      end else r_s_v <= w_s_left;
    end
  // Read and write share one process so a same-word collision returns the old word
  always_ff @(posedge ACLK) begin
    if (w_issue) r_rq <= r_mem[f_idx(r_raddr)];
    if (w_w_hs && !w_w_oor)
      for (int i = 0; i < STRB_WIDTH; i++)
        if (m_WSTRB[i]) r_mem[f_idx(r_waddr)][i*8 +: 8] <= m_WDATA[i*8 +: 8];
  end
endmodule

// File: tb/tb_axi_burst_ram.sv
// tb_axi_burst_ram: scoreboard bench for axi_burst_ram with a byte-level memory model
module tb_axi_burst_ram;
  localparam int IW = 1;
  localparam int DEPTH = 16384;
  localparam logic [31:0] TOP = DEPTH * 4;
  logic ACLK = 1'b0;
  always #5 ACLK = ~ACLK;
  logic ARESET;
  logic [IW-1:0] m_AWID, m_BID, m_ARID, m_RID;
  logic [31:0] m_AWADDR, m_ARADDR, m_WDATA, m_RDATA;
  logic [7:0] m_AWLEN, m_ARLEN;
  logic [2:0] m_AWSIZE, m_ARSIZE;
  logic [1:0] m_AWBURST, m_ARBURST, m_BRESP, m_RRESP;
  logic [3:0] m_WSTRB;
  logic m_AWVALID, m_AWREADY, m_WLAST, m_WVALID, m_WREADY, m_BVALID, m_BREADY;
  logic m_ARVALID, m_ARREADY, m_RLAST, m_RVALID, m_RREADY;
  axi_burst_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(IW), .DEPTH(DEPTH)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .m_AWID(m_AWID), .m_AWADDR(m_AWADDR), .m_AWLEN(m_AWLEN), .m_AWSIZE(m_AWSIZE),
    .m_AWBURST(m_AWBURST), .m_AWVALID(m_AWVALID), .m_AWREADY(m_AWREADY),
    .m_WDATA(m_WDATA), .m_WSTRB(m_WSTRB), .m_WLAST(m_WLAST), .m_WVALID(m_WVALID), .m_WREADY(m_WREADY),
    .m_BID(m_BID), .m_BRESP(m_BRESP), .m_BVALID(m_BVALID), .m_BREADY(m_BREADY),
    .m_ARID(m_ARID), .m_ARADDR(m_ARADDR), .m_ARLEN(m_ARLEN), .m_ARSIZE(m_ARSIZE),
    .m_ARBURST(m_ARBURST), .m_ARVALID(m_ARVALID), .m_ARREADY(m_ARREADY),
    .m_RID(m_RID), .m_RDATA(m_RDATA), .m_RRESP(m_RRESP), .m_RLAST(m_RLAST),
    .m_RVALID(m_RVALID), .m_RREADY(m_RREADY)
  );
  typedef struct {
    logic [31:0]   data;
    logic [1:0]    resp;
    logic          last;
    logic [IW-1:0] id;
  } beat_t;
  beat_t q[$];
  beat_t e_mon;
  logic [31:0] mdl [int];
  int errs = 0;
  int checks = 0;
  int rbeats = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] mdl_rd(input logic [31:0] a);
    return mdl.exists(int'(a >> 2)) ? mdl[int'(a >> 2)] : 32'h0;
  endfunction
  logic stall = 1'b0;
  logic [31:0] s_data;
  logic s_last;
  always @(negedge ACLK)
    if (!ARESET) begin
      if (stall) begin
        chk("hold_valid", 64'(m_RVALID), 64'd1);
        chk("hold_data", 64'(m_RDATA), 64'(s_data));
        chk("hold_last", 64'(m_RLAST), 64'(s_last));
      end
      stall = m_RVALID && !m_RREADY;
      s_data = m_RDATA;
      s_last = m_RLAST;
      if (m_RVALID && m_RREADY) begin
        rbeats++;
        if (q.size() == 0) chk("r_extra_beat", 64'(q.size()), 64'd1);
        else begin
          e_mon = q.pop_front();
          chk("rdata", 64'(m_RDATA), 64'(e_mon.data));
          chk("rresp", 64'(m_RRESP), 64'(e_mon.resp));
          chk("rlast", 64'(m_RLAST), 64'(e_mon.last));
          chk("rid", 64'(m_RID), 64'(e_mon.id));
        end
      end
    end else stall = 1'b0;
  task automatic wr(input logic [31:0] addr, input int len, input logic [31:0] d0, input logic [31:0] step,
                    input logic [3:0] s, input logic [IW-1:0] id, input bit early);
    logic [31:0] a, w;
    bit err;
    int n;
    a = addr;
    err = early && len > 0;
    @(posedge ACLK); #1;
    m_AWID = id; m_AWADDR = addr; m_AWLEN = 8'(len); m_AWSIZE = 3'd2; m_AWBURST = 2'd1; m_AWVALID = 1'b1;
    for (n = 0; n < 50; n++) begin @(negedge ACLK); if (m_AWREADY) break; end
    chk("aw_ready_in_time", 64'(n < 50), 64'd1);
    @(posedge ACLK); #1 m_AWVALID = 1'b0;
    for (int i = 0; i <= len; i++) begin
      m_WDATA = d0 + step * i; m_WSTRB = s; m_WLAST = early ? i == 0 : i == len; m_WVALID = 1'b1;
      for (n = 0; n < 50; n++) begin @(negedge ACLK); if (m_WREADY) break; end
      chk("w_ready_in_time", 64'(n < 50), 64'd1);
      if (a < TOP) begin
        w = mdl_rd(a);
        for (int b = 0; b < 4; b++) if (s[b]) w[b*8 +: 8] = m_WDATA[b*8 +: 8];
        mdl[int'(a >> 2)] = w;
      end else err = 1'b1;
      a += 4;
      @(posedge ACLK); #1;
    end
    m_WVALID = 1'b0; m_WLAST = 1'b0;
    for (n = 0; n < 50; n++) begin @(negedge ACLK); if (m_BVALID) break; end
    chk("b_valid_in_time", 64'(n < 50), 64'd1);
    chk("bresp", 64'(m_BRESP), err ? 64'd2 : 64'd0);
    chk("bid", 64'(m_BID), 64'(id));
    @(posedge ACLK); #1;
  endtask
  task automatic rd(input logic [31:0] addr, input int len, input logic [1:0] bt, input logic [IW-1:0] id,
                    input bit lat);
    logic [31:0] a, lo, tot;
    bit perr, wok;
    beat_t e;
    int n;
    wok = len == 1 || len == 3 || len == 7 || len == 15;
    perr = bt == 2'd3 || (bt == 2'd2 && !wok);
    tot = 32'((len + 1) * 4);
    lo = addr - (addr % tot);
    for (int i = 0; i <= len; i++) begin
      a = bt == 2'd0 ? addr : (bt == 2'd2 && wok) ? lo + ((addr - lo + 32'(i * 4)) % tot) : addr + 32'(i * 4);
      e.data = a >= TOP ? 32'h0 : mdl_rd(a);
      e.resp = (perr || a >= TOP) ? 2'd2 : 2'd0;
      e.last = i == len;
      e.id = id;
      q.push_back(e);
    end
    @(posedge ACLK); #1;
    m_ARID = id; m_ARADDR = addr; m_ARLEN = 8'(len); m_ARSIZE = 3'd2; m_ARBURST = bt; m_ARVALID = 1'b1;
    for (n = 0; n < 50; n++) begin @(negedge ACLK); if (m_ARREADY) break; end
    chk("ar_ready_in_time", 64'(n < 50), 64'd1);
    @(posedge ACLK); #1 m_ARVALID = 1'b0;
    if (lat) begin
      for (n = 1; n <= 10; n++) begin @(negedge ACLK); if (m_RVALID) break; end
      chk("first_rvalid_cycle", 64'(n), 64'd2);
      repeat (len) begin @(negedge ACLK); chk("no_bubble", 64'(m_RVALID), 64'd1); end
    end
  endtask
  task automatic drain();
    int n;
    for (n = 0; n < 300; n++) begin if (q.size() == 0) break; @(negedge ACLK); end
    chk("drain_left", 64'(q.size()), 64'd0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end
  initial begin
    logic [4:0] pat;
    int r0, n;
    pat = 5'b11001;
    ARESET = 1'b1;
    m_AWID = '0; m_AWADDR = '0; m_AWLEN = '0; m_AWSIZE = '0; m_AWBURST = '0; m_AWVALID = 1'b0;
    m_WDATA = '0; m_WSTRB = '0; m_WLAST = 1'b0; m_WVALID = 1'b0; m_BREADY = 1'b1;
    m_ARID = '0; m_ARADDR = '0; m_ARLEN = '0; m_ARSIZE = '0; m_ARBURST = '0; m_ARVALID = 1'b0;
    m_RREADY = 1'b1;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_awready", 64'(m_AWREADY), 64'd0);
    chk("rst_arready", 64'(m_ARREADY), 64'd0);
    chk("rst_wready", 64'(m_WREADY), 64'd0);
    chk("rst_bvalid", 64'(m_BVALID), 64'd0);
    chk("rst_rvalid", 64'(m_RVALID), 64'd0);
    chk("rst_rlast", 64'(m_RLAST), 64'd0);
    chk("rst_rdata", 64'(m_RDATA), 64'd0);
    @(posedge ACLK); #1 ARESET = 1'b0;
    @(negedge ACLK);
    chk("post_rst_awready", 64'(m_AWREADY), 64'd1);
    chk("post_rst_arready", 64'(m_ARREADY), 64'd1);
    wr(32'h100, 3, 32'hA0, 32'h1, 4'hF, 1'b1, 1'b0);
    rd(32'h100, 3, 2'd1, 1'b1, 1'b1);
    drain();
    wr(32'h40, 0, 32'hFFFF_FFFF, 32'h0, 4'hF, 1'b0, 1'b0);
    wr(32'h40, 0, 32'h1122_3344, 32'h0, 4'b0101, 1'b0, 1'b0);
    rd(32'h40, 0, 2'd1, 1'b0, 1'b0);
    drain();
    wr(32'h100, 3, 32'h1, 32'h1, 4'hF, 1'b0, 1'b0);
    rd(32'h108, 3, 2'd2, 1'b0, 1'b0);
    rd(32'h100, 2, 2'd0, 1'b1, 1'b0);
    drain();
    wr(32'h200, 7, 32'h5000, 32'h3, 4'hF, 1'b1, 1'b0);
    rd(32'h200, 7, 2'd1, 1'b1, 1'b0);
    for (int k = 0; k < 15; k++) begin m_RREADY = pat[k % 5]; @(posedge ACLK); #1; end
    m_RREADY = 1'b1;
    drain();
    wr(TOP - 4, 1, 32'hC0DE_0000, 32'h1, 4'hF, 1'b1, 1'b0);
    rd(TOP - 4, 1, 2'd1, 1'b0, 1'b0);
    drain();
    wr(32'h300, 1, 32'h77, 32'h1, 4'hF, 1'b1, 1'b1);
    rd(32'h300, 1, 2'd3, 1'b1, 1'b0);
    rd(32'h100, 2, 2'd2, 1'b0, 1'b0);
    drain();
    r0 = rbeats;
    rd(32'h100, 3, 2'd1, 1'b0, 1'b0);
    for (n = 0; n < 50; n++) begin @(negedge ACLK); if (rbeats > r0) break; end
    chk("mid_burst_beat_seen", 64'(n < 50), 64'd1);
    @(posedge ACLK); #1 ARESET = 1'b1;
    q.delete();
    @(negedge ACLK);
    chk("midrst_rvalid", 64'(m_RVALID), 64'd0);
    chk("midrst_arready", 64'(m_ARREADY), 64'd0);
    @(posedge ACLK); #1 ARESET = 1'b0;
    @(negedge ACLK);
    chk("after_rst_arready", 64'(m_ARREADY), 64'd1);
    chk("after_rst_rvalid", 64'(m_RVALID), 64'd0);
    rd(32'h100, 3, 2'd1, 1'b1, 1'b1);
    drain();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
